led_blink_array: RTL and testbench

Parametrised multi-channel LED driver that replaces a single fixed-rate blinker. A shared prescaler produces a slow tick. Each of CHANNELS outputs is independently configured as OFF, ON, BLINK (toggle at a programmable period) or PWM (programmable period and duty). It sits between board-level LED pins and whatever control logic writes its configuration port.

---
 rtl/led_blink_array.sv | 115 +++++++++++
 tb/tb_led_blink_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_array.sv
// Multi-channel LED driver: shared tick prescaler plus per-channel OFF/ON/BLINK/PWM
// pattern generators, configured one channel at a time through a valid/ready port.
module led_blink_array #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESCALE = 50,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic                tick,
    output logic [CHANNELS-1:0] io_led
);

    localparam int unsigned PS_W = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [PS_W-1:0]     ps_q, ps_d;
    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];
    logic [CNT_W-1:0]    period_q [CHANNELS];
    logic [CNT_W-1:0]    period_d [CHANNELS];
    logic [CNT_W-1:0]    duty_q   [CHANNELS];
    logic [CNT_W-1:0]    duty_d   [CHANNELS];
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic                wr_en;
    logic [CNT_W-1:0]    wrap_cnt;

    // Ready is withheld on tick cycles so a write and a pattern step never collide.
    assign tick      = (ps_q == PS_W'(PRESCALE - 1));
    assign cfg_ready = ~tick;
    assign io_led    = led_q;
    assign wr_en     = cfg_valid && cfg_ready
                       && ({1'b0, cfg_chan} < (CH_W + 1)'(CHANNELS));

    always_comb begin
        ps_d     = tick ? '0 : ps_q + PS_W'(1);
        led_d    = led_q;
        wrap_cnt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            duty_d[i]   = duty_q[i];
            cnt_d[i]    = cnt_q[i];
            if (tick) begin
                wrap_cnt = (cnt_q[i] == period_q[i]) ? '0 : cnt_q[i] + CNT_W'(1);
                unique case (mode_q[i])
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: begin
                        cnt_d[i] = wrap_cnt;
                        if (cnt_q[i] == period_q[i]) begin
                            led_d[i] = ~led_q[i];
                        end
                    end
                    MODE_PWM: begin
                        cnt_d[i] = wrap_cnt;
                        led_d[i] = (wrap_cnt < duty_q[i]);
                    end
                    default: led_d[i] = 1'b0;
                endcase
            end else if (wr_en && (cfg_chan == CH_W'(i))) begin
                // A write always restarts the pattern from its start value.
                mode_d[i]   = mode_e'(cfg_mode);
                period_d[i] = cfg_period;
                duty_d[i]   = cfg_duty;
                cnt_d[i]    = '0;
                unique case (mode_e'(cfg_mode))
                    MODE_OFF:   led_d[i] = 1'b0;
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: led_d[i] = 1'b1;
                    MODE_PWM:   led_d[i] = (cfg_duty != '0);
                    default:    led_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q  <= '0;
            led_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            ps_q  <= ps_d;
            led_q <= led_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                duty_q[i]   <= duty_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_blink_array.sv
// Directed bench for led_blink_array at PRESCALE=4; a second 3-channel instance
// shares the stimulus to exercise out-of-range channel writes.
module tb_led_blink_array;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_PWM   = 2'd3;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic        tick;
    logic [3:0]  io_led;
    logic        cfg_ready3;
    logic        tick3;
    logic [2:0]  io_led3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    led_blink_array #(.CHANNELS(4), .CNT_W(16), .PRESCALE(4)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .tick(tick), .io_led(io_led)
    );

    led_blink_array #(.CHANNELS(3), .CNT_W(16), .PRESCALE(4)) dut3 (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .tick(tick3), .io_led(io_led3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // After return the bench sits in cycle 0 following the last reset edge.
    task automatic do_reset();
        reset     = 1'b1;
        cfg_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [1:0] md,
                             input logic [15:0] per, input logic [15:0] dty);
        cfg_chan   = ch;
        cfg_mode   = md;
        cfg_period = per;
        cfg_duty   = dty;
        cfg_valid  = 1'b1;
        for (int n = 0; n < 4 && cfg_ready !== 1'b1; n++) step();
        if (cfg_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL write_timeout cyc=%0d cfg_ready=%b required=1", cyc, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_tick;
        do_reset();
        checks++;
        if (io_led !== 4'b0000) begin
            errors++;
            $display("FAIL reset_led cyc=%0d got=%b exp=0000", cyc, io_led);
        end
        while (cyc <= 11) begin
            exp_tick = ((cyc % 4) == 3);
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL reset_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick);
            end
            checks++;
            if (cfg_ready !== ~exp_tick) begin
                errors++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, ~exp_tick);
            end
            step();
        end
    endtask

    task automatic test_blink();
        logic exp;
        do_reset();
        write_cfg(2'd0, M_BLINK, 16'd0, 16'd0);
        while (cyc <= 15) begin
            exp = (((cyc / 4) % 2) == 0);
            checks++;
            if (io_led[0] !== exp) begin
                errors++;
                $display("FAIL blink_p0 cyc=%0d got=%b exp=%b", cyc, io_led[0], exp);
            end
            step();
        end
        write_cfg(2'd0, M_BLINK, 16'd2, 16'd0);
        while (cyc <= 52) begin
            exp = ((((cyc - 16) / 12) % 2) == 0);
            checks++;
            if (io_led[0] !== exp) begin
                errors++;
                $display("FAIL blink_p2 cyc=%0d got=%b exp=%b", cyc, io_led[0], exp);
            end
            step();
        end
    endtask

    task automatic test_pwm();
        logic exp;
        do_reset();
        write_cfg(2'd1, M_PWM, 16'd3, 16'd1);
        while (cyc <= 35) begin
            exp = (((cyc / 4) % 4) == 0);
            checks++;
            if (io_led[1] !== exp) begin
                errors++;
                $display("FAIL pwm_d1 cyc=%0d got=%b exp=%b", cyc, io_led[1], exp);
            end
            step();
        end
        write_cfg(2'd1, M_PWM, 16'd3, 16'd0);
        while (cyc <= 52) begin
            checks++;
            if (io_led[1] !== 1'b0) begin
                errors++;
                $display("FAIL pwm_d0 cyc=%0d got=%b exp=0", cyc, io_led[1]);
            end
            step();
        end
        write_cfg(2'd1, M_PWM, 16'd3, 16'd5);
        while (cyc <= 68) begin
            checks++;
            if (io_led[1] !== 1'b1) begin
                errors++;
                $display("FAIL pwm_d5 cyc=%0d got=%b exp=1", cyc, io_led[1]);
            end
            step();
        end
    endtask

    task automatic test_handshake();
        do_reset();
        step();
        step();
        step();
        cfg_chan   = 2'd2;
        cfg_mode   = M_ON;
        cfg_period = 16'd0;
        cfg_duty   = 16'd0;
        cfg_valid  = 1'b1;
        checks++;
        if (cfg_ready !== 1'b0 || tick !== 1'b1) begin
            errors++;
            $display("FAIL hs_tick_cycle cyc=%0d ready=%b tick=%b exp ready=0 tick=1",
                     cyc, cfg_ready, tick);
        end
        step();
        checks++;
        if (io_led[2] !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_no_accept cyc=%0d led2=%b ready=%b exp led2=0 ready=1",
                     cyc, io_led[2], cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (io_led !== 4'b0100) begin
            errors++;
            $display("FAIL hs_accept cyc=%0d got=%b exp=0100", cyc, io_led);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        write_cfg(2'd3, M_ON, 16'd0, 16'd0);
        checks++;
        if (io_led !== 4'b1000) begin
            errors++;
            $display("FAIL oor_ch3_valid cyc=%0d got=%b exp=1000", cyc, io_led);
        end
        while (cyc <= 8) begin
            checks++;
            if (io_led3 !== 3'b000) begin
                errors++;
                $display("FAIL oor_ignored cyc=%0d got=%b exp=000", cyc, io_led3);
            end
            step();
        end
    endtask

    task automatic test_independence();
        logic exp0;
        logic exp1;
        do_reset();
        write_cfg(2'd0, M_BLINK, 16'd1, 16'd0);
        write_cfg(2'd1, M_PWM, 16'd1, 16'd1);
        while (cyc <= 23) begin
            exp0 = (((cyc / 8) % 2) == 0);
            exp1 = (((cyc / 4) % 2) == 0);
            checks++;
            if (io_led[1:0] !== {exp1, exp0}) begin
                errors++;
                $display("FAIL indep_run cyc=%0d got=%b exp=%b", cyc, io_led[1:0], {exp1, exp0});
            end
            step();
        end
        write_cfg(2'd0, M_OFF, 16'd0, 16'd0);
        while (cyc <= 39) begin
            exp1 = (((cyc / 4) % 2) == 0);
            checks++;
            if (io_led[1:0] !== {exp1, 1'b0}) begin
                errors++;
                $display("FAIL indep_off cyc=%0d got=%b exp=%b", cyc, io_led[1:0], {exp1, 1'b0});
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic exp_tick;
        do_reset();
        write_cfg(2'd0, M_BLINK, 16'd0, 16'd0);
        write_cfg(2'd1, M_PWM, 16'd3, 16'd2);
        while (cyc < 6) step();
        checks++;
        if (io_led !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_pattern cyc=%0d got=%b exp=0010", cyc, io_led);
        end
        reset      = 1'b1;
        cfg_chan   = 2'd2;
        cfg_mode   = M_ON;
        cfg_period = 16'd0;
        cfg_duty   = 16'd0;
        cfg_valid  = 1'b1;
        step();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cyc       = 0;
        checks++;
        if (io_led !== 4'b0000 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_reset cyc=%0d led=%b ready=%b exp led=0000 ready=1",
                     cyc, io_led, cfg_ready);
        end
        while (cyc <= 11) begin
            exp_tick = ((cyc % 4) == 3);
            checks++;
            if (io_led !== 4'b0000 || tick !== exp_tick) begin
                errors++;
                $display("FAIL rmid_after cyc=%0d led=%b tick=%b exp led=0000 tick=%b",
                         cyc, io_led, tick, exp_tick);
            end
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_mode   = M_OFF;
        cfg_period = 16'd0;
        cfg_duty   = 16'd0;
        test_reset();
        test_blink();
        test_pwm();
        test_handshake();
        test_out_of_range();
        test_independence();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
        $fatal(1);
    end

endmodule
